// File: rtl/priv_ext_router.sv
`default_nettype none
// ============================================================================
// Module      : priv_ext_router
// Description : Routes one CSR request at a time from the privileged CSR unit
//               to NUM_EXT extension CSR files. Broadcasts the latched address
//               and write data, picks the lowest-index claiming extension,
//               strobes a one-cycle write to it and returns a registered
//               response (ack / invalid / read data). Multi-claims are flagged.
//               Optional build macro PRIV_EXT_ACK_TIMEOUT_EN lets LOOKUP wait
//               up to ACK_TIMEOUT cycles for extensions with registered decode.
// Revision    : 1.0 - initial release
// ============================================================================
module priv_ext_router #(
    parameter int NUM_EXT     = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [11:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_ack,
    output logic                  rsp_invalid,
    output logic [31:0]           rsp_rdata,
    output logic [11:0]           ext_csr_addr,
    output logic [31:0]           ext_value_in,
    output logic [NUM_EXT-1:0]    ext_csr_active,
    input  logic [NUM_EXT-1:0]    ext_ack,
    input  logic [NUM_EXT-1:0]    ext_invalid_csr,
    input  logic [32*NUM_EXT-1:0] ext_value_out
);

    localparam int C_IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [11:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic [C_IDX_W-1:0]   win_q, win_d;
    logic                 ack_q, ack_d;
    logic                 inv_q, inv_d;
    logic [31:0]          rdata_q, rdata_d;

`ifdef PRIV_EXT_ACK_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [C_IDX_W-1:0]   w_win_idx;
    logic [31:0]          w_win_rdata;
    logic                 w_win_inv;
    logic                 w_any_ack;
    logic                 w_multi_ack;
    logic                 w_commit_inv;

    // Resolve the claim: lowest set index wins; flag more than one claimant.
    always_comb begin
        w_win_idx   = '0;
        w_win_rdata = '0;
        w_win_inv   = 1'b0;
        w_any_ack   = 1'b0;
        w_multi_ack = 1'b0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (ext_ack[i]) begin
                w_win_idx   = C_IDX_W'(i);
                w_win_rdata = ext_value_out[32*i +: 32];
                w_win_inv   = ext_invalid_csr[i];
            end
        end
        for (int i = 0; i < NUM_EXT; i++) begin
            if (ext_ack[i]) begin
                if (w_any_ack) begin
                    w_multi_ack = 1'b1;
                end
                w_any_ack = 1'b1;
            end
        end
    end

    // Decode the latched winner into the write strobe and its commit-time error.
    always_comb begin
        ext_csr_active = '0;
        w_commit_inv   = 1'b0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (win_q == C_IDX_W'(i)) begin
                ext_csr_active[i] = (state_q == S_COMMIT);
                w_commit_inv      = ext_invalid_csr[i];
            end
        end
    end

    // Next-state and response capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        win_d   = win_q;
        ack_d   = ack_q;
        inv_d   = inv_q;
        rdata_d = rdata_q;
`ifdef PRIV_EXT_ACK_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wr_d    = req_write;
                    ack_d   = 1'b0;
                    inv_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_LOOKUP;
`ifdef PRIV_EXT_ACK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_LOOKUP: begin
                if (!w_any_ack) begin
`ifdef PRIV_EXT_ACK_TIMEOUT_EN
                    // Keep waiting until ACK_TIMEOUT lookup cycles have elapsed.
                    if (cnt_q == C_CNT_W'(ACK_TIMEOUT - 1)) begin
                        ack_d   = 1'b0;
                        inv_d   = 1'b0;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    ack_d   = 1'b0;
                    inv_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_RESP;
`endif
                end else begin
                    win_d   = w_win_idx;
                    rdata_d = w_win_rdata;
                    ack_d   = 1'b1;
                    if (w_multi_ack) begin
                        // Conflicting claims never commit a write.
                        inv_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (wr_q && !w_win_inv) begin
                        inv_d   = 1'b0;
                        state_d = S_COMMIT;
                    end else begin
                        inv_d   = w_win_inv;
                        state_d = S_RESP;
                    end
                end
            end
            S_COMMIT: begin
                inv_d   = inv_q | w_commit_inv;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any request in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            win_q   <= '0;
            ack_q   <= 1'b0;
            inv_q   <= 1'b0;
            rdata_q <= '0;
`ifdef PRIV_EXT_ACK_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            win_q   <= win_d;
            ack_q   <= ack_d;
            inv_q   <= inv_d;
            rdata_q <= rdata_d;
`ifdef PRIV_EXT_ACK_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_ack      = ack_q;
    assign rsp_invalid  = inv_q;
    assign rsp_rdata    = rdata_q;
    assign ext_csr_addr = addr_q;
    assign ext_value_in = wdata_q;

endmodule
`default_nettype wire
